// File: rtl/dram_wbl_stream_loader.sv
// Streams a programmable, wrapping address range of multi-lane WBL words from a
// request/valid source into the DRAM write controller, with per-write timeout retry.
`timescale 1ns/1ps
module dram_wbl_stream_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned LANES     = 16,
    parameter int unsigned LANE_W    = 64,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      START,
    input  logic                      ABORT,
    input  logic [ADDR_W-1:0]         BASE_ADDR,
    input  logic [ADDR_W-1:0]         LAST_ADDR,
    output logic                      SRC_REQ,
    output logic [ADDR_W-1:0]         SRC_ADDR,
    input  logic                      SRC_VALID,
    input  logic [LANES*LANE_W-1:0]   SRC_DATA,
    output logic                      IO_EN,
    output logic [ADDR_W-1:0]         ADDR,
    output logic [LANES*LANE_W-1:0]   WBL_DATA,
    input  logic                      wr_done,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR,
    output logic [ADDR_W-1:0]         ERR_ADDR
);

    localparam int unsigned DW    = LANES * LANE_W;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_SRC,
        S_ISSUE,
        S_WAIT_ACK,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [DW-1:0]       wbl_q, wbl_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic                src_req_q, src_req_d;
    logic                io_en_q, io_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        err_addr_d = err_addr_q;
        wbl_d      = wbl_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        done_d     = done_q;
        err_d      = err_q;
        src_req_d  = 1'b0;
        io_en_d    = 1'b0;

        // ABORT outranks every other event, so it is resolved before the state decode.
        if (ABORT && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        addr_d     = BASE_ADDR;
                        end_d      = LAST_ADDR;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        err_addr_d = '0;
                        retry_d    = '0;
                        src_req_d  = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                S_REQ: state_d = S_WAIT_SRC;
                S_WAIT_SRC: begin
                    if (SRC_VALID) begin
                        wbl_d   = SRC_DATA;
                        retry_d = '0;
                        io_en_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (wr_done) begin
                        if (addr_q == end_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d    = addr_q + ADDR_W'(1);
                            src_req_d = 1'b1;
                            state_d   = S_REQ;
                        end
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        // Expiry is decided in the TIMEOUT-th wait cycle so the re-issue
                        // lands TIMEOUT+1 cycles after the previous strobe.
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RTY_W'(1);
                            io_en_d = 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            err_d      = 1'b1;
                            err_addr_d = addr_q;
                            state_d    = S_FAIL;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_FAIL:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            err_addr_q <= '0;
            wbl_q      <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            src_req_q  <= 1'b0;
            io_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            err_addr_q <= err_addr_d;
            wbl_q      <= wbl_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            src_req_q  <= src_req_d;
            io_en_q    <= io_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign SRC_REQ  = src_req_q;
    assign SRC_ADDR = addr_q;
    assign IO_EN    = io_en_q;
    assign ADDR     = addr_q;
    assign WBL_DATA = wbl_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_dram_wbl_stream_loader.sv
// Scoreboard bench: stimulus queues expected write strobes, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dram_wbl_stream_loader;

    localparam int AW = 6;
    localparam int LN = 16;
    localparam int LW = 64;
    localparam int TO = 8;
    localparam int MR = 2;
    localparam int DW = LN * LW;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW-1:0] LAST_ADDR = '0;
    logic          SRC_REQ;
    logic [AW-1:0] SRC_ADDR;
    logic          SRC_VALID = 1'b0;
    logic [DW-1:0] SRC_DATA = '0;
    logic          IO_EN;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] WBL_DATA;
    logic          wr_done = 1'b0;
    logic          BUSY, DONE, ERR;
    logic [AW-1:0] ERR_ADDR;

    dram_wbl_stream_loader #(
        .ADDR_W(AW), .LANES(LN), .LANE_W(LW), .TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .ABORT(ABORT),
        .BASE_ADDR(BASE_ADDR), .LAST_ADDR(LAST_ADDR),
        .SRC_REQ(SRC_REQ), .SRC_ADDR(SRC_ADDR), .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA),
        .IO_EN(IO_EN), .ADDR(ADDR), .WBL_DATA(WBL_DATA), .wr_done(wr_done),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_ADDR(ERR_ADDR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   salt = 0;
    int   cyc = 0;
    int   io_cnt = 0;
    int   src_req_cnt = 0;
    int   src_hold_addr = -1;
    int   nack_addr = -1;
    int   nack_limit = 0;
    int   nack_seen = 0;

    function automatic logic [DW-1:0] pattern(input int a, input int s);
        logic [DW-1:0] w;
        for (int i = 0; i < LN; i++)
            w[i*LW +: LW] = {16'(s), 16'(a), 16'(i), 16'hC0DE ^ 16'(a * 16 + i)};
        return w;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic push_addr(input int a);
        sb.push_back('{a, pattern(a, salt)});
    endtask

    task automatic push_run(input int base, input int last);
        int n;
        n = ((last - base + 64) % 64) + 1;
        for (int k = 0; k < n; k++) push_addr((base + k) % 64);
    endtask

    task automatic start_run(input int base, input int last);
        @(posedge CLK); #1;
        BASE_ADDR = AW'(base);
        LAST_ADDR = AW'(last);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("start_busy", BUSY, 1);
        chk("start_src_req", SRC_REQ, 1);
        chk("start_src_addr", SRC_ADDR, base);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < limit) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= limit) fail_now(name);
    endtask

    task automatic wait_io_at(input string name, input int a);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(IO_EN === 1'b1 && ADDR == AW'(a)) && n < 300);
        if (n >= 300) fail_now(name);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops one expectation per write strobe; back-to-back strobes at the
    // same address within one run are retries and must be TIMEOUT+1 cycles apart.
    initial begin : monitor
        exp_t e;
        int   prev_io;
        int   prev_cyc;
        prev_io = -1;
        prev_cyc = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn || !BUSY) prev_io = -1;
            if (RSTn) begin
                if (SRC_REQ) src_req_cnt++;
                if (IO_EN) begin
                    io_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_io_en actual ADDR=%0d required none", ADDR);
                    end else begin
                        e = sb.pop_front();
                        if (ADDR !== AW'(e.addr) || WBL_DATA !== e.data) begin
                            failures++;
                            $display("FAIL io_write actual ADDR=%0d data=%h required ADDR=%0d data=%h",
                                     ADDR, WBL_DATA[127:0], e.addr, e.data[127:0]);
                        end
                    end
                    if (prev_io == int'(ADDR)) chk("retry_gap", cyc - prev_cyc, TO + 1);
                    prev_io = int'(ADDR);
                    prev_cyc = cyc;
                end
            end
        end
    end

    initial begin : source
        int a;
        forever begin
            @(negedge CLK);
            if (RSTn && SRC_REQ && int'(SRC_ADDR) != src_hold_addr) begin
                a = int'(SRC_ADDR);
                @(posedge CLK); #1;
                SRC_VALID = 1'b1;
                SRC_DATA = pattern(a, salt);
                @(posedge CLK); #1;
                SRC_VALID = 1'b0;
            end
        end
    end

    initial begin : controller
        int a;
        bit ack;
        forever begin
            @(negedge CLK);
            if (RSTn && IO_EN) begin
                a = int'(ADDR);
                ack = 1'b1;
                if (a == nack_addr) begin
                    if (nack_seen < nack_limit) ack = 1'b0;
                    nack_seen++;
                end
                if (ack) begin
                    @(posedge CLK); #1;
                    wr_done = 1'b1;
                    @(posedge CLK); #1;
                    wr_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, io0, r0;
        #2;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_io_en", IO_EN, 0);
        chk("rst_src_req", SRC_REQ, 0);
        chk("rst_wbl_zero", WBL_DATA == '0, 1);
        @(negedge CLK);
        RSTn = 1'b1;

        // Full 64-word range, zero-wait; a START mid-run must be ignored.
        salt = 1;
        push_run(0, 63);
        start_run(0, 63);
        n = 0;
        while (DONE !== 1'b1 && n < 400) begin
            if (n == 50) begin BASE_ADDR = 6'd40; LAST_ADDR = 6'd45; START = 1'b1; end
            if (n == 51) START = 1'b0;
            @(posedge CLK); #1;
            n++;
        end
        chk("full_done_latency", n, 256);
        chk("full_busy_after_done", BUSY, 0);
        chk("full_err", ERR, 0);

        // Wrapping range and single word.
        salt = 2;
        push_run(62, 1);
        start_run(62, 1);
        wait_idle("wrap_idle", 100);
        chk("wrap_done", DONE, 1);
        chk("wrap_last_addr", ADDR, 1);
        salt = 3;
        io0 = io_cnt;
        push_run(5, 5);
        start_run(5, 5);
        wait_idle("single_idle", 100);
        chk("single_count", io_cnt - io0, 1);
        chk("single_done", DONE, 1);

        // Two ignored strobes at address 3, then acked on the last retry.
        salt = 4;
        nack_addr = 3; nack_limit = 2; nack_seen = 0;
        push_addr(2); push_addr(3); push_addr(3); push_addr(3); push_addr(4);
        start_run(2, 4);
        wait_idle("retry_idle", 200);
        chk("retry_done", DONE, 1);
        chk("retry_err", ERR, 0);

        // Address 3 never acked: retries exhausted.
        salt = 5;
        nack_addr = 3; nack_limit = 1000; nack_seen = 0;
        push_addr(2); push_addr(3); push_addr(3); push_addr(3);
        start_run(2, 4);
        wait_idle("err_idle", 200);
        chk("err_flag", ERR, 1);
        chk("err_addr", ERR_ADDR, 3);
        chk("err_done", DONE, 0);
        chk("err_busy", BUSY, 0);
        nack_addr = -1;
        salt = 6;
        push_run(7, 7);
        start_run(7, 7);
        chk("err_cleared", ERR, 0);
        wait_idle("err_restart_idle", 100);
        chk("err_restart_done", DONE, 1);

        // ABORT while waiting on the source at address 10.
        salt = 7;
        src_hold_addr = 10;
        push_addr(8); push_addr(9);
        start_run(8, 20);
        n = 0;
        do begin @(negedge CLK); n++; end while (!(SRC_REQ === 1'b1 && SRC_ADDR == 6'd10) && n < 100);
        if (n >= 100) fail_now("abort_src_wait");
        @(posedge CLK); #1; ABORT = 1'b1;
        @(posedge CLK); #1; ABORT = 1'b0;
        chk("abort_src_busy", BUSY, 0);
        chk("abort_src_req", SRC_REQ, 0);
        chk("abort_src_io_en", IO_EN, 0);
        chk("abort_src_done", DONE, 0);
        chk("abort_src_addr", ADDR, 10);
        r0 = src_req_cnt; io0 = io_cnt;
        repeat (20) @(posedge CLK);
        chk("abort_src_no_req", src_req_cnt - r0, 0);
        chk("abort_src_no_io", io_cnt - io0, 0);
        src_hold_addr = -1;

        // ABORT coinciding with wr_done at address 32.
        salt = 8;
        push_addr(30); push_addr(31); push_addr(32);
        start_run(30, 40);
        wait_io_at("abort_ack_wait", 32);
        @(posedge CLK); #1; ABORT = 1'b1;
        @(posedge CLK); #1; ABORT = 1'b0;
        chk("abort_ack_busy", BUSY, 0);
        chk("abort_ack_addr", ADDR, 32);
        chk("abort_ack_done", DONE, 0);
        r0 = src_req_cnt; io0 = io_cnt;
        repeat (20) @(posedge CLK);
        chk("abort_ack_no_req", src_req_cnt - r0, 0);
        chk("abort_ack_no_io", io_cnt - io0, 0);

        // Asynchronous reset during WAIT_ACK, then a clean restart.
        salt = 9;
        nack_addr = 22; nack_limit = 1000; nack_seen = 0;
        push_addr(20); push_addr(21); push_addr(22);
        start_run(20, 25);
        wait_io_at("rst_wait", 22);
        @(posedge CLK); #3;
        RSTn = 1'b0;
        #1;
        chk("arst_busy", BUSY, 0);
        chk("arst_addr", ADDR, 0);
        chk("arst_src_addr", SRC_ADDR, 0);
        chk("arst_io_en", IO_EN, 0);
        chk("arst_err_addr", ERR_ADDR, 0);
        chk("arst_wbl_zero", WBL_DATA == '0, 1);
        @(negedge CLK);
        RSTn = 1'b1;
        nack_addr = -1;
        io0 = io_cnt;
        repeat (15) @(posedge CLK);
        chk("arst_no_io", io_cnt - io0, 0);
        salt = 10;
        push_run(50, 52);
        start_run(50, 52);
        wait_idle("arst_restart_idle", 100);
        chk("arst_restart_done", DONE, 1);
        chk("arst_restart_addr", ADDR, 52);

        repeat (3) @(posedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
